// File: rtl/rob_update_arbiter_pkg.sv
// rob_update_arbiter_pkg: shared widths, update payload bundle, helpers.
// Supplies ROB_IDX / SCALAR / ROB_ARB_NREQ when sys_defs.vh has not.
`ifndef ROB_IDX
`define ROB_IDX 5
`endif
`ifndef SCALAR
`define SCALAR 1
`endif
`ifndef ROB_ARB_NREQ
`define ROB_ARB_NREQ 4
`endif

package rob_update_arbiter_pkg;

   localparam int ROB_IDX_W = `ROB_IDX;
   localparam int MAX_REQ   = 8;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [63:0]          ba;
      logic                 bt;
   } rob_upd_t;

   // index of the set bit in a one-hot vector (0 when empty)
   function automatic int oh_enc(logic [MAX_REQ-1:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rob_update_arbiter_rr_pick.sv
// rr_pick: first set bit of mask scanning upward from start, wrapping.
// Ports: mask, start in; onehot, found out.
module rr_pick
   import rob_update_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] start,
   output logic [N-1:0]  onehot,
   output logic          found
);

   // k is scan distance from start; j is the bit that sits k away
   always_comb begin
      onehot = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && mask[j] &&
                j == (int'(start) + k) % N) begin
               onehot[j] = 1'b1;
               found     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_update_arbiter.sv
// rob_update_arbiter: grants up to two of NUM_REQ completion requesters
// per cycle onto the ROB dup1/dup2 update ports, rotating priority.
// Ports: req_* in, req_ready out, flush in, dup*/..._out* registered,
// grant_cnt out. Option: ROB_ARB_BR_PRIO_EN picks branches first.
module rob_update_arbiter
   import rob_update_arbiter_pkg::*;
#(
   parameter int NUM_REQ = `ROB_ARB_NREQ,
   parameter int PTR_W   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_isbr,
   input  logic [NUM_REQ*`ROB_IDX-1:0]    req_rob_idx,
   input  logic [NUM_REQ*64-1:0]          req_ba_ex,
   input  logic [NUM_REQ-1:0]             req_bt_ex,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           flush,
   output logic                           dup1_req,
   output logic                           dup2_req,
   output logic [`ROB_IDX-1:0]            rob_idx_out1,
   output logic [`ROB_IDX-1:0]            rob_idx_out2,
   output logic [63:0]                    ba_ex_out1,
   output logic [63:0]                    ba_ex_out2,
   output logic                           bt_ex_out1,
   output logic                           bt_ex_out2,
   output logic [1:0]                     grant_cnt
);

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_nxt;
   logic [NUM_REQ-1:0] oh_a;
   logic [NUM_REQ-1:0] oh_b;
   logic               found_a;
   logic               found_b;
   logic               gnt_a;
   logic               gnt_b;
   logic [PTR_W-1:0]   idx_a;
   logic [PTR_W-1:0]   idx_b;
   rob_upd_t           upd_a;
   rob_upd_t           upd_b;

`ifdef ROB_ARB_BR_PRIO_EN
   logic [NUM_REQ-1:0] br_m;
   logic [NUM_REQ-1:0] nb_m;
   logic [NUM_REQ-1:0] oh_br;
   logic [NUM_REQ-1:0] oh_nb;
   logic [NUM_REQ-1:0] oh_br2;
   logic [NUM_REQ-1:0] oh_nb2;
   logic               f_br;
   logic               f_nb;
   logic               f_br2;
   logic               f_nb2;

   assign br_m = req_valid & req_isbr;
   assign nb_m = req_valid & ~req_isbr;

   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_br (
      .mask(br_m), .start(ptr),
      .onehot(oh_br), .found(f_br)
   );
   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_nb (
      .mask(nb_m), .start(ptr),
      .onehot(oh_nb), .found(f_nb)
   );
   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_br2 (
      .mask(br_m & ~oh_br), .start(ptr),
      .onehot(oh_br2), .found(f_br2)
   );
   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_nb2 (
      .mask(nb_m & ~oh_nb), .start(ptr),
      .onehot(oh_nb2), .found(f_nb2)
   );

   // a branch always takes slot A; slot B falls back to the
   // first non-branch once the branches run out
   always_comb begin
      oh_a    = oh_nb;
      found_a = f_nb;
      oh_b    = oh_nb2;
      found_b = f_nb2;
      if (f_br) begin
         oh_a    = oh_br;
         found_a = 1'b1;
         oh_b    = f_br2 ? oh_br2 : oh_nb;
         found_b = f_br2 | f_nb;
      end
   end
`else
   logic unused_isbr;
   assign unused_isbr = ^req_isbr;

   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_a (
      .mask(req_valid), .start(ptr),
      .onehot(oh_a), .found(found_a)
   );
   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick_b (
      .mask(req_valid & ~oh_a), .start(ptr),
      .onehot(oh_b), .found(found_b)
   );
`endif

   always_comb begin
      req_ready = '0;
      grant_cnt = 2'd0;
      gnt_a     = 1'b0;
      gnt_b     = 1'b0;
      if (!reset && !flush) begin
         gnt_a     = found_a;
         gnt_b     = found_b;
         req_ready = oh_a | oh_b;
         grant_cnt = {1'b0, found_a} + {1'b0, found_b};
      end
   end

   assign idx_a = PTR_W'(oh_enc(MAX_REQ'(oh_a)));
   assign idx_b = PTR_W'(oh_enc(MAX_REQ'(oh_b)));

   // one extra bit so last+1 == NUM_REQ is representable before wrap
   always_comb begin
      logic [PTR_W:0] inc;
      inc     = {1'b0, (gnt_b ? idx_b : idx_a)} + (PTR_W+1)'(1);
      if (inc >= (PTR_W+1)'(NUM_REQ)) begin
         inc = inc - (PTR_W+1)'(NUM_REQ);
      end
      ptr_nxt = ptr;
      if (gnt_a) ptr_nxt = inc[PTR_W-1:0];
   end

   always_comb begin
      upd_a = '0;
      upd_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh_a[i]) begin
            upd_a.rob_idx = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            upd_a.ba      = req_ba_ex[i*64 +: 64];
            upd_a.bt      = req_bt_ex[i];
         end
         if (oh_b[i]) begin
            upd_b.rob_idx = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            upd_b.ba      = req_ba_ex[i*64 +: 64];
            upd_b.bt      = req_bt_ex[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr          <= '0;
         dup1_req     <= 1'b0;
         dup2_req     <= 1'b0;
         rob_idx_out1 <= '0;
         rob_idx_out2 <= '0;
         ba_ex_out1   <= '0;
         ba_ex_out2   <= '0;
         bt_ex_out1   <= 1'b0;
         bt_ex_out2   <= 1'b0;
      end else begin
         ptr      <= ptr_nxt;
         dup1_req <= gnt_a;
         dup2_req <= gnt_b;
         if (gnt_a) begin
            rob_idx_out1 <= upd_a.rob_idx;
            ba_ex_out1   <= upd_a.ba;
            bt_ex_out1   <= upd_a.bt;
         end
         if (gnt_b) begin
            rob_idx_out2 <= upd_b.rob_idx;
            ba_ex_out2   <= upd_b.ba;
            bt_ex_out2   <= upd_b.bt;
         end
      end
   end

endmodule

// File: tb/tb_rob_update_arbiter.sv
// tb_rob_update_arbiter: directed steps for rob_update_arbiter.
// Inputs driven and outputs sampled on the falling edge.
`ifndef ROB_IDX
`define ROB_IDX 5
`endif
`ifndef ROB_ARB_NREQ
`define ROB_ARB_NREQ 4
`endif

module tb_rob_update_arbiter;

   localparam int N  = `ROB_ARB_NREQ;
   localparam int IW = `ROB_IDX;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_isbr;
   logic [N*IW-1:0] req_rob_idx;
   logic [N*64-1:0] req_ba_ex;
   logic [N-1:0]    req_bt_ex;
   logic [N-1:0]    req_ready;
   logic            flush;
   logic            dup1_req;
   logic            dup2_req;
   logic [IW-1:0]   rob_idx_out1;
   logic [IW-1:0]   rob_idx_out2;
   logic [63:0]     ba_ex_out1;
   logic [63:0]     ba_ex_out2;
   logic            bt_ex_out1;
   logic            bt_ex_out2;
   logic [1:0]      grant_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rob_update_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_isbr(req_isbr),
      .req_rob_idx(req_rob_idx),
      .req_ba_ex(req_ba_ex),
      .req_bt_ex(req_bt_ex),
      .req_ready(req_ready),
      .flush(flush),
      .dup1_req(dup1_req),
      .dup2_req(dup2_req),
      .rob_idx_out1(rob_idx_out1),
      .rob_idx_out2(rob_idx_out2),
      .ba_ex_out1(ba_ex_out1),
      .ba_ex_out2(ba_ex_out2),
      .bt_ex_out1(bt_ex_out1),
      .bt_ex_out2(bt_ex_out2),
      .grant_cnt(grant_cnt)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(int i, int idx, logic [63:0] ba, logic bt);
      req_rob_idx[i*IW +: IW] = IW'(idx);
      req_ba_ex[i*64 +: 64]   = ba;
      req_bt_ex[i]            = bt;
   endtask

   // requester i: rob_idx 16+i, ba 0xA000+i, bt = i odd
   task automatic load_all();
      for (int i = 0; i < N; i++) begin
         set_req(i, 16 + i, 64'hA000 + 64'(i), logic'(i % 2));
      end
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      req_valid   = '1;
      req_isbr    = '0;
      req_rob_idx = '0;
      req_ba_ex   = '0;
      req_bt_ex   = '0;
      load_all();

      @(negedge clk); #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_cnt", 64'(grant_cnt), 64'h0);

      @(negedge clk);
      chk("rst_dup1", 64'(dup1_req), 64'h0);
      chk("rst_dup2", 64'(dup2_req), 64'h0);
      chk("rst_idx1", 64'(rob_idx_out1), 64'h0);
      chk("rst_ba2", ba_ex_out2, 64'h0);
      chk("rst_bt1", 64'(bt_ex_out1), 64'h0);
      reset     = 1'b0;
      req_valid = '0;
      #1;
      chk("idle_ready", 64'(req_ready), 64'h0);
      chk("idle_cnt", 64'(grant_cnt), 64'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_dup1", 64'(dup1_req), 64'h0);
         chk("idle_dup2", 64'(dup2_req), 64'h0);
      end

      // all four valid from ptr 0
      req_valid = 4'b1111;
      #1;
      chk("rr0_ready", 64'(req_ready), 64'h3);
      chk("rr0_cnt", 64'(grant_cnt), 64'h2);
      @(negedge clk);
      chk("rr0_dup1", 64'(dup1_req), 64'h1);
      chk("rr0_dup2", 64'(dup2_req), 64'h1);
      chk("rr0_idx1", 64'(rob_idx_out1), 64'd16);
      chk("rr0_idx2", 64'(rob_idx_out2), 64'd17);
      chk("rr0_ba1", ba_ex_out1, 64'hA000);
      chk("rr0_bt1", 64'(bt_ex_out1), 64'h0);
      chk("rr0_bt2", 64'(bt_ex_out2), 64'h1);
      #1;
      chk("rr1_ready", 64'(req_ready), 64'hC);
      @(negedge clk);
      chk("rr1_idx1", 64'(rob_idx_out1), 64'd18);
      chk("rr1_idx2", 64'(rob_idx_out2), 64'd19);
      chk("rr1_ba2", ba_ex_out2, 64'hA003);
      #1;
      chk("rr2_ready", 64'(req_ready), 64'h3);
      @(negedge clk);
      chk("rr2_idx1", 64'(rob_idx_out1), 64'd16);
      chk("rr2_idx2", 64'(rob_idx_out2), 64'd17);

      // only requester 2, ptr now 2 -> ptr becomes 3
      req_valid = 4'b0100;
      set_req(2, 5, 64'h1000, 1'b1);
      #1;
      chk("one_ready", 64'(req_ready), 64'h4);
      chk("one_cnt", 64'(grant_cnt), 64'h1);
      @(negedge clk);
      chk("one_dup1", 64'(dup1_req), 64'h1);
      chk("one_dup2", 64'(dup2_req), 64'h0);
      chk("one_idx1", 64'(rob_idx_out1), 64'd5);
      chk("one_ba1", ba_ex_out1, 64'h1000);
      chk("one_bt1", 64'(bt_ex_out1), 64'h1);
      #1;
      chk("p3_ready", 64'(req_ready), 64'h4);
      @(negedge clk);
      chk("p3_dup1", 64'(dup1_req), 64'h1);
      chk("p3_dup2", 64'(dup2_req), 64'h0);
      chk("p3_idx2_hold", 64'(rob_idx_out2), 64'd17);

      // ptr 3, valid 1001 -> A=3, B=0, ptr becomes 1
      req_valid = 4'b1001;
      set_req(3, 9, 64'h3333, 1'b0);
      set_req(0, 7, 64'h7777, 1'b1);
      #1;
      chk("wrap_ready", 64'(req_ready), 64'h9);
      chk("wrap_cnt", 64'(grant_cnt), 64'h2);
      @(negedge clk);
      chk("wrap_idx1", 64'(rob_idx_out1), 64'd9);
      chk("wrap_ba1", ba_ex_out1, 64'h3333);
      chk("wrap_bt1", 64'(bt_ex_out1), 64'h0);
      chk("wrap_idx2", 64'(rob_idx_out2), 64'd7);
      chk("wrap_ba2", ba_ex_out2, 64'h7777);
      chk("wrap_bt2", 64'(bt_ex_out2), 64'h1);
      req_valid = 4'b1111;
      load_all();
      #1;
      chk("p1_ready", 64'(req_ready), 64'h6);
      @(negedge clk);
      chk("p1_idx1", 64'(rob_idx_out1), 64'd17);
      chk("p1_idx2", 64'(rob_idx_out2), 64'd18);

      // flush with everything valid, ptr 3
      flush = 1'b1;
      #1;
      chk("fl_ready", 64'(req_ready), 64'h0);
      chk("fl_cnt", 64'(grant_cnt), 64'h0);
      chk("fl_dup1_prev", 64'(dup1_req), 64'h1);
      chk("fl_idx1_prev", 64'(rob_idx_out1), 64'd17);
      @(negedge clk);
      chk("fl_dup1", 64'(dup1_req), 64'h0);
      chk("fl_dup2", 64'(dup2_req), 64'h0);
      chk("fl_idx1_hold", 64'(rob_idx_out1), 64'd17);
      flush = 1'b0;
      #1;
      chk("pf_ready", 64'(req_ready), 64'h9);
      @(negedge clk);
      chk("pf_idx1", 64'(rob_idx_out1), 64'd19);
      chk("pf_idx2", 64'(rob_idx_out2), 64'd16);
      req_valid = '0;
      #1;
      chk("nog_cnt", 64'(grant_cnt), 64'h0);
      @(negedge clk);
      chk("nog_dup1", 64'(dup1_req), 64'h0);
      chk("nog_idx1_hold", 64'(rob_idx_out1), 64'd19);

      // reset while requests pending
      req_valid = 4'b1111;
      reset     = 1'b1;
      #1;
      chk("mr_ready", 64'(req_ready), 64'h0);
      chk("mr_cnt", 64'(grant_cnt), 64'h0);
      @(negedge clk);
      chk("mr_dup1", 64'(dup1_req), 64'h0);
      chk("mr_idx1", 64'(rob_idx_out1), 64'h0);
      chk("mr_ba1", ba_ex_out1, 64'h0);
      reset    = 1'b0;
      req_isbr = 4'b1000;
      #1;
`ifdef ROB_ARB_BR_PRIO_EN
      chk("br_ready", 64'(req_ready), 64'h9);
      @(negedge clk);
      chk("br_idx1", 64'(rob_idx_out1), 64'd19);
      chk("br_idx2", 64'(rob_idx_out2), 64'd16);
`else
      chk("br_ready", 64'(req_ready), 64'h3);
      @(negedge clk);
      chk("br_idx1", 64'(rob_idx_out1), 64'd16);
      chk("br_idx2", 64'(rob_idx_out2), 64'd17);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
